mcpu5_prog_server: RTL

//  Responder side of the MCPU5 instruction bus. It serves 6-bit instructions for the 8-bit

---
 rtl/mcpu5_pkg.sv | 18 +
 rtl/mcpu5_out_fifo.sv | 85 ++++++++
 rtl/mcpu5_prog_server.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/mcpu5_pkg.sv
// Shared constants and types for the MCPU5 program server and its output-capture FIFO.
package mcpu5_pkg;

    localparam int ADDR_W = 8;
    localparam int INST_W = 6;

    localparam logic [INST_W-1:0] OUT_OPCODE_DEF = 6'b111011;
    localparam logic [INST_W-1:0] IDLE_INST_DEF  = 6'b111001;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_CRST,
        ST_RUN,
        ST_DONE
    } state_t;

endpackage

// File: rtl/mcpu5_out_fifo.sv
// Output-capture FIFO with registered head/valid. A push and a pop in the same cycle both
// take effect, even when full. Pushes into a full FIFO with no pop are dropped.
module mcpu5_out_fifo
    import mcpu5_pkg::*;
#(
    parameter int DATA_W = ADDR_W,
    parameter int DEPTH  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              drop
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

    logic [DATA_W-1:0] fifo_mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  rd_nxt;
    logic [CNT_W-1:0]  count;
    logic [CNT_W-1:0]  count_nxt;
    logic              full;
    logic              empty;
    logic              pop_ok;
    logic              push_ok;
    logic              head_is_new;

    assign empty   = (count == '0);
    assign full    = (count == CNT_FULL);
    assign pop_ok  = out_ready && !empty;
    assign push_ok = push && (!full || pop_ok);
    assign drop    = push && full && !pop_ok;
    assign rd_nxt  = rd_ptr + PTR_W'(pop_ok);

    // The slot at rd_nxt is still being written this edge when the FIFO drains to the new word.
    assign head_is_new = push_ok && (empty || (count == CNT_ONE && pop_ok));

    always_comb begin
        count_nxt = count;
        if (push_ok && !pop_ok) begin
            count_nxt = count + CNT_ONE;
        end else if (!push_ok && pop_ok) begin
            count_nxt = count - CNT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            fifo_mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            rd_ptr    <= rd_nxt;
            count     <= count_nxt;
            out_valid <= (count_nxt != '0);
            if (head_is_new) begin
                out_data <= push_data;
            end else if (count_nxt != '0) begin
                out_data <= fifo_mem[rd_nxt];
            end
        end
    end

endmodule

// File: rtl/mcpu5_prog_server.sv
// Instruction-bus responder for the MCPU5 core: loadable program array, core reset/run
// sequencing, and capture of every value the core emits with an OUT instruction.
module mcpu5_prog_server
    import mcpu5_pkg::*;
#(
    parameter logic [INST_W-1:0] OUT_OPCODE = OUT_OPCODE_DEF,
    parameter logic [INST_W-1:0] IDLE_INST  = IDLE_INST_DEF,
    parameter int                RST_CYCLES = 2,
    parameter logic [15:0]       MAX_CYCLES = 16'd10000,
    parameter int                FIFO_DEPTH = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_valid,
    output logic              load_ready,
    input  logic [INST_W-1:0] load_data,
    input  logic              load_last,
    input  logic              start,
    input  logic              stop,
    input  logic [ADDR_W-1:0] cpu_addr,
    output logic [INST_W-1:0] cpu_inst,
    output logic              cpu_rst,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_data,
    output logic              busy,
    output logic              done,
    output logic              overflow,
    output logic [15:0]       cycles
);

    localparam logic [7:0]        RST_LAST = 8'(RST_CYCLES - 1);
    localparam logic [15:0]       CYC_LAST = MAX_CYCLES - 16'd1;
    localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);

    state_t            state;
    state_t            state_nxt;
    logic [INST_W-1:0] prog_mem [2**ADDR_W];
    logic [ADDR_W-1:0] load_ptr;
    logic [7:0]        rst_cnt;
    logic              load_acc;
    logic              cap_pend;
    logic              fifo_clr;
    logic              fifo_drop;

    assign load_acc = load_ready && load_valid;
    assign fifo_clr = (state == ST_CRST) && (rst_cnt == 8'd0);

    // Zero-latency fetch: the core samples cpu_inst on the same edge it presents cpu_addr.
    assign cpu_inst = (state == ST_RUN) ? prog_mem[cpu_addr] : IDLE_INST;

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_nxt = ST_CRST;
                end else if (load_valid) begin
                    state_nxt = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (load_acc && load_last) begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_CRST: begin
                if (rst_cnt == RST_LAST) begin
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (stop || cycles == CYC_LAST) begin
                    state_nxt = ST_DONE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            load_ready <= 1'b0;
            cpu_rst    <= 1'b1;
            busy       <= 1'b0;
            done       <= 1'b0;
            load_ptr   <= '0;
            rst_cnt    <= 8'd0;
            cycles     <= 16'd0;
            cap_pend   <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            state      <= state_nxt;
            load_ready <= (state_nxt == ST_LOAD);
            cpu_rst    <= (state_nxt != ST_RUN);
            busy       <= (state_nxt == ST_LOAD) || (state_nxt == ST_CRST) || (state_nxt == ST_RUN);
            done       <= (state_nxt == ST_DONE);

            // Holding the pointer at zero outside LOAD makes every new load start at address 0.
            if (state != ST_LOAD) begin
                load_ptr <= '0;
            end else if (load_acc) begin
                load_ptr <= load_ptr + PTR_ONE;
            end

            rst_cnt <= (state == ST_CRST) ? rst_cnt + 8'd1 : 8'd0;

            if (state == ST_CRST) begin
                cycles <= 16'd0;
            end else if (state == ST_RUN && cycles != 16'hFFFF) begin
                cycles <= cycles + 16'd1;
            end

            // The OUT value appears on cpu_addr one cycle after the opcode is served.
            cap_pend <= (state == ST_RUN) && (cpu_inst == OUT_OPCODE);

            if (fifo_clr) begin
                overflow <= 1'b0;
            end else if (fifo_drop) begin
                overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && load_acc) begin
            prog_mem[load_ptr] <= load_data;
        end
    end

    mcpu5_out_fifo #(
        .DATA_W (ADDR_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_out_fifo (
        .clk       (clk),
        .rst       (reset),
        .clr       (fifo_clr),
        .push      (cap_pend),
        .push_data (cpu_addr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .drop      (fifo_drop)
    );

endmodule
